// File: rtl/payload_pkg.sv
// Shared definitions for the payload character decoder: class indices,
// the case-insensitive byte-to-class table and the control FSM states.
package payload_pkg;

    localparam int NUM_CLASSES = 64;

    localparam int CLS_WS     = 1;
    localparam int CLS_DIGIT  = 2;
    localparam int CLS_N      = 3;
    localparam int CLS_W      = 4;
    localparam int CLS_E      = 17;
    localparam int CLS_T      = 18;
    localparam int CLS_LPAREN = 42;
    localparam int CLS_RPAREN = 43;
    localparam int CLS_SEMI   = 44;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SOD    = 2'd1,
        ST_STREAM = 2'd2,
        ST_EOD    = 2'd3
    } state_e;

    // Upper-case letters fold onto lower case before the lookup.
    function automatic logic [NUM_CLASSES-1:0] char_class(input logic [7:0] b);
        logic [7:0]             lc;
        logic [NUM_CLASSES-1:0] v;
        v = '0;
        if (b >= 8'h41 && b <= 8'h5A) begin
            lc = b | 8'h20;
        end else begin
            lc = b;
        end
        case (lc)
            8'h20, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D: v[CLS_WS] = 1'b1;
            8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
            8'h35, 8'h36, 8'h37, 8'h38, 8'h39:        v[CLS_DIGIT] = 1'b1;
            8'h6E:                                    v[CLS_N] = 1'b1;
            8'h77:                                    v[CLS_W] = 1'b1;
            8'h65:                                    v[CLS_E] = 1'b1;
            8'h74:                                    v[CLS_T] = 1'b1;
            8'h28:                                    v[CLS_LPAREN] = 1'b1;
            8'h29:                                    v[CLS_RPAREN] = 1'b1;
            8'h3B:                                    v[CLS_SEMI] = 1'b1;
            default:                                  v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/payload_word_serializer.sv
// Word buffer with keep-scan: hands out the kept byte lanes of one buffered
// word in ascending order and decides when the next word may be accepted.
module payload_word_serializer import payload_pkg::*; #(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_keep,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    input  logic                arm_i,
    input  logic                idle_i,
    input  logic                step_i,
    output logic                byte_vld_o,
    output logic [7:0]          byte_o,
    output logic                word_done_o,
    output logic                word_last_o
);

    localparam int NL = DATA_W / 8;

    logic [DATA_W-1:0] data_q, data_d;
    logic [NL-1:0]     keep_q, keep_d;
    logic              last_q, last_d;
    logic              full_q, full_d;

    logic [NL-1:0]     low_onehot_s;
    logic [NL-1:0]     rest_s;
    logic              accept_s;
    logic [7:0]        byte_s;

    assign low_onehot_s = keep_q & (~keep_q + NL'(1));
    assign rest_s       = keep_q & ~low_onehot_s;

    // An all-zero keep word is consumed in a single step with no byte.
    assign byte_vld_o  = step_i & full_q & (|keep_q);
    assign word_done_o = step_i & full_q & (rest_s == '0);
    assign word_last_o = last_q;
    assign byte_o      = byte_s;

    // The word closing a packet never lets the next packet in behind it.
    assign s_ready  = arm_i & (idle_i | (step_i & (~full_q | (word_done_o & ~last_q))));
    assign accept_s = s_valid & s_ready;

    // One-hot lane select of the lowest remaining kept lane.
    always_comb begin
        byte_s = 8'h00;
        for (int i = 0; i < NL; i++) begin
            if (low_onehot_s[i]) begin
                byte_s = byte_s | data_q[i*8 +: 8];
            end else begin
                byte_s = byte_s;
            end
        end
    end

    always_comb begin
        data_d = data_q;
        keep_d = keep_q;
        last_d = last_q;
        full_d = full_q;
        if (accept_s) begin
            data_d = s_data;
            keep_d = s_keep;
            last_d = s_last;
            full_d = 1'b1;
        end else begin
            if (byte_vld_o) begin
                keep_d = rest_s;
            end else begin
                keep_d = keep_q;
            end
            if (word_done_o) begin
                full_d = 1'b0;
            end else begin
                full_d = full_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            keep_q <= keep_d;
            last_q <= last_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/payload_char_decoder.sv
// Packet payload front end: serialises words to bytes, classifies each byte
// and generates the sod/en/eod strobes for the downstream engines.
module payload_char_decoder import payload_pkg::*; #(
    parameter int DATA_W      = 64,
    parameter int NUM_CLASSES = payload_pkg::NUM_CLASSES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      s_data,
    input  logic [DATA_W/8-1:0]    s_keep,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [NUM_CLASSES-1:0] cls,
    output logic                   en,
    output logic                   sod,
    output logic                   eod
);

    state_e state_q, state_d;
    logic   arm_q;

    logic       sod_s, eod_s, idle_s, step_s;
    logic       byte_vld_s, word_done_s, word_last_s;
    logic [7:0] byte_s;

    logic       p1_vld_q, p1_vld_d;
    logic [7:0] p1_byte_q, p1_byte_d;
    logic       p1_sod_q, p1_sod_d;
    logic       p1_eod_q, p1_eod_d;

    logic                   en_q, en_d;
    logic [NUM_CLASSES-1:0] cls_q, cls_d;
    logic                   sod_q, sod_d;
    logic                   eod_q, eod_d;

    payload_word_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_keep      (s_keep),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .arm_i       (arm_q),
        .idle_i      (idle_s),
        .step_i      (step_s),
        .byte_vld_o  (byte_vld_s),
        .byte_o      (byte_s),
        .word_done_o (word_done_s),
        .word_last_o (word_last_s)
    );

    // SOD is a dedicated cycle because the engine clear dominates its enable.
    always_comb begin
        state_d = state_q;
        sod_s   = 1'b0;
        eod_s   = 1'b0;
        idle_s  = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_s = 1'b1;
                if (s_valid && s_ready) begin
                    state_d = ST_SOD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SOD: begin
                sod_s   = 1'b1;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                step_s = 1'b1;
                if (word_done_s && word_last_s) begin
                    state_d = ST_EOD;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_EOD: begin
                eod_s   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= 1'b1;
        end
    end

    // sod and eod ride the same two stages as the bytes so ordering is preserved.
    always_comb begin
        p1_vld_d  = byte_vld_s;
        p1_byte_d = byte_s;
        p1_sod_d  = sod_s;
        p1_eod_d  = eod_s;
        en_d      = p1_vld_q;
        sod_d     = p1_sod_q;
        eod_d     = p1_eod_q;
        if (p1_vld_q) begin
            cls_d = NUM_CLASSES'(char_class(p1_byte_q));
        end else begin
            cls_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_vld_q  <= 1'b0;
            p1_byte_q <= 8'h00;
            p1_sod_q  <= 1'b0;
            p1_eod_q  <= 1'b0;
            en_q      <= 1'b0;
            cls_q     <= '0;
            sod_q     <= 1'b0;
            eod_q     <= 1'b0;
        end else begin
            p1_vld_q  <= p1_vld_d;
            p1_byte_q <= p1_byte_d;
            p1_sod_q  <= p1_sod_d;
            p1_eod_q  <= p1_eod_d;
            en_q      <= en_d;
            cls_q     <= cls_d;
            sod_q     <= sod_d;
            eod_q     <= eod_d;
        end
    end

    assign en  = en_q;
    assign cls = cls_q;
    assign sod = sod_q;
    assign eod = eod_q;

endmodule

// File: tb/tb_payload_char_decoder.sv
// Directed self-checking bench for payload_char_decoder.
module tb_payload_char_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [63:0] cls;
    logic        en;
    logic        sod;
    logic        eod;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int leak   = 0;
    int overlap = 0;

    int          sod_l[$];
    int          en_l[$];
    int          eod_l[$];
    logic [63:0] cls_l[$];

    localparam logic [63:0] B1  = 64'h0000_0000_0000_0002;
    localparam logic [63:0] B2  = 64'h0000_0000_0000_0004;
    localparam logic [63:0] B3  = 64'h0000_0000_0000_0008;
    localparam logic [63:0] B4  = 64'h0000_0000_0000_0010;
    localparam logic [63:0] B17 = 64'h0000_0000_0002_0000;
    localparam logic [63:0] B42 = 64'h0000_0400_0000_0000;
    localparam logic [63:0] B43 = 64'h0000_0800_0000_0000;

    payload_char_decoder dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .cls     (cls),
        .en      (en),
        .sod     (sod),
        .eod     (eod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sod) sod_l.push_back(cyc);
        if (eod) eod_l.push_back(cyc);
        if (en) begin
            en_l.push_back(cyc);
            cls_l.push_back(cls);
        end
        if (en === 1'b0 && cls !== 64'd0 && rst === 1'b0) leak++;
        if (sod && en) overlap++;
    end

    task automatic clear_log();
        sod_l.delete();
        en_l.delete();
        eod_l.delete();
        cls_l.delete();
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_word_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = 64'd0; s_keep = 8'd0; s_last = 1'b0;
        @(posedge clk); #1;
        checks++; if (en !== 1'b0)    begin errors++; $display("FAIL reset_en: got %b want 0", en); end
        checks++; if (sod !== 1'b0)   begin errors++; $display("FAIL reset_sod: got %b want 0", sod); end
        checks++; if (eod !== 1'b0)   begin errors++; $display("FAIL reset_eod: got %b want 0", eod); end
        checks++; if (cls !== 64'd0)  begin errors++; $display("FAIL reset_cls: got %h want 0", cls); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", s_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_new_paren();
        logic [63:0] exp_c [5];
        exp_c[0] = B3; exp_c[1] = B17; exp_c[2] = B4; exp_c[3] = B1; exp_c[4] = B42;
        clear_log();
        send_word(64'h0000_0028_2077_656E, 8'h1F, 1'b1);
        drain(14);
        checks++; if (sod_l.size() != 1) begin errors++; $display("FAIL new_sod_count: got %0d want 1", sod_l.size()); end
        checks++; if (en_l.size() != 5)  begin errors++; $display("FAIL new_en_count: got %0d want 5", en_l.size()); end
        checks++; if (eod_l.size() != 1) begin errors++; $display("FAIL new_eod_count: got %0d want 1", eod_l.size()); end
        if (sod_l.size() == 1 && en_l.size() == 5 && eod_l.size() == 1) begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (en_l[i] != sod_l[0] + 1 + i) begin
                    errors++; $display("FAIL new_en_cycle[%0d]: got t+%0d want t+%0d", i, en_l[i] - sod_l[0], i + 1);
                end
                checks++;
                if (cls_l[i] !== exp_c[i]) begin
                    errors++; $display("FAIL new_cls[%0d]: got %h want %h", i, cls_l[i], exp_c[i]);
                end
            end
            checks++;
            if (eod_l[0] != sod_l[0] + 6) begin
                errors++; $display("FAIL new_eod_cycle: got t+%0d want t+6", eod_l[0] - sod_l[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_word(64'h4847_4645_4443_4241, 8'hFF, 1'b0);
        send_word(64'h296E_2820_3332_3130, 8'hFF, 1'b1);
        drain(16);
        checks++; if (en_l.size() != 16) begin errors++; $display("FAIL b2b_en_count: got %0d want 16", en_l.size()); end
        checks++; if (sod_l.size() != 1) begin errors++; $display("FAIL b2b_sod_count: got %0d want 1", sod_l.size()); end
        checks++; if (eod_l.size() != 1) begin errors++; $display("FAIL b2b_eod_count: got %0d want 1", eod_l.size()); end
        if (en_l.size() == 16 && sod_l.size() == 1 && eod_l.size() == 1) begin
            checks++; if (en_l[15] - en_l[0] != 15) begin errors++; $display("FAIL b2b_span: got %0d want 15", en_l[15] - en_l[0]); end
            checks++; if (sod_l[0] != en_l[0] - 1)  begin errors++; $display("FAIL b2b_sod_lead: got %0d want %0d", sod_l[0], en_l[0] - 1); end
            checks++; if (eod_l[0] != en_l[15] + 1) begin errors++; $display("FAIL b2b_eod_lag: got %0d want %0d", eod_l[0], en_l[15] + 1); end
            checks++; if (cls_l[0] !== 64'd0) begin errors++; $display("FAIL b2b_cls_A: got %h want 0", cls_l[0]); end
            checks++; if (cls_l[4] !== B17)   begin errors++; $display("FAIL b2b_cls_E: got %h want %h", cls_l[4], B17); end
            checks++; if (cls_l[8] !== B2)    begin errors++; $display("FAIL b2b_cls_0: got %h want %h", cls_l[8], B2); end
            checks++; if (cls_l[13] !== B42)  begin errors++; $display("FAIL b2b_cls_lp: got %h want %h", cls_l[13], B42); end
            checks++; if (cls_l[15] !== B43)  begin errors++; $display("FAIL b2b_cls_rp: got %h want %h", cls_l[15], B43); end
        end
    endtask

    task automatic test_sparse_keep();
        clear_log();
        send_word(64'h0000_0000_0028_656E, 8'h05, 1'b1);
        drain(12);
        checks++; if (en_l.size() != 2) begin errors++; $display("FAIL sparse_en_count: got %0d want 2", en_l.size()); end
        if (en_l.size() == 2 && eod_l.size() == 1) begin
            checks++; if (cls_l[0] !== B3)  begin errors++; $display("FAIL sparse_cls0: got %h want %h", cls_l[0], B3); end
            checks++; if (cls_l[1] !== B42) begin errors++; $display("FAIL sparse_cls1: got %h want %h", cls_l[1], B42); end
            checks++; if (en_l[1] != en_l[0] + 1) begin errors++; $display("FAIL sparse_gap: got %0d want 1", en_l[1] - en_l[0]); end
            checks++; if (eod_l[0] != en_l[1] + 1) begin errors++; $display("FAIL sparse_eod: got %0d want %0d", eod_l[0], en_l[1] + 1); end
        end else begin
            checks++; errors++;
            $display("FAIL sparse_shape: en=%0d eod=%0d want 2/1", en_l.size(), eod_l.size());
        end
    endtask

    task automatic test_single_bytes();
        logic [7:0]  bv [5];
        logic [63:0] ev [5];
        bv[0] = 8'h4E; ev[0] = B3;
        bv[1] = 8'h6E; ev[1] = B3;
        bv[2] = 8'h45; ev[2] = B17;
        bv[3] = 8'h09; ev[3] = B1;
        bv[4] = 8'h7F; ev[4] = 64'd0;
        for (int i = 0; i < 5; i++) begin
            clear_log();
            send_word({56'd0, bv[i]}, 8'h01, 1'b1);
            drain(10);
            if (sod_l.size() == 1 && en_l.size() == 1 && eod_l.size() == 1) begin
                checks++; if (cls_l[0] !== ev[i]) begin errors++; $display("FAIL single_cls[%h]: got %h want %h", bv[i], cls_l[0], ev[i]); end
                checks++; if (en_l[0] != sod_l[0] + 1 || eod_l[0] != en_l[0] + 1) begin
                    errors++; $display("FAIL single_timing[%h]: sod=%0d en=%0d eod=%0d want consecutive", bv[i], sod_l[0], en_l[0], eod_l[0]);
                end
            end else begin
                checks++; errors++;
                $display("FAIL single_shape[%h]: sod=%0d en=%0d eod=%0d want 1/1/1", bv[i], sod_l.size(), en_l.size(), eod_l.size());
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int seen;
        int n;
        clear_log();
        send_word(64'h4847_4645_4443_4241, 8'hFF, 1'b1);
        seen = 0; n = 0;
        while (seen < 3 && n < 30) begin
            @(posedge clk); #1;
            if (en === 1'b1) seen++;
            n++;
        end
        checks++; if (seen != 3) begin errors++; $display("FAIL rstmid_wait: saw %0d bytes want 3", seen); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (en !== 1'b0 || sod !== 1'b0 || eod !== 1'b0 || cls !== 64'd0) begin
            errors++; $display("FAIL rstmid_outputs: en=%b sod=%b eod=%b cls=%h want all 0", en, sod, eod, cls);
        end
        drain(14);
        checks++; if (eod_l.size() != 0) begin errors++; $display("FAIL rstmid_no_eod: got %0d want 0", eod_l.size()); end
        checks++; if (en_l.size() != 3)  begin errors++; $display("FAIL rstmid_en_count: got %0d want 3", en_l.size()); end
        clear_log();
        send_word(64'h0000_0000_0000_0045, 8'h01, 1'b1);
        drain(10);
        if (sod_l.size() == 1 && en_l.size() == 1 && eod_l.size() == 1) begin
            checks++; if (en_l[0] != sod_l[0] + 1) begin errors++; $display("FAIL rstmid_next_sod: en-sod=%0d want 1", en_l[0] - sod_l[0]); end
            checks++; if (cls_l[0] !== B17) begin errors++; $display("FAIL rstmid_next_cls: got %h want %h", cls_l[0], B17); end
        end else begin
            checks++; errors++;
            $display("FAIL rstmid_next_shape: sod=%0d en=%0d eod=%0d want 1/1/1", sod_l.size(), en_l.size(), eod_l.size());
        end
    endtask

    task automatic test_empty_last();
        clear_log();
        send_word(64'hDEAD_BEEF_0000_0000, 8'h00, 1'b1);
        drain(10);
        checks++; if (sod_l.size() != 1) begin errors++; $display("FAIL empty_sod_count: got %0d want 1", sod_l.size()); end
        checks++; if (en_l.size() != 0)  begin errors++; $display("FAIL empty_en_count: got %0d want 0", en_l.size()); end
        checks++; if (eod_l.size() != 1) begin errors++; $display("FAIL empty_eod_count: got %0d want 1", eod_l.size()); end
        if (sod_l.size() == 1 && eod_l.size() == 1) begin
            checks++; if (eod_l[0] != sod_l[0] + 2) begin errors++; $display("FAIL empty_eod_cycle: got sod+%0d want sod+2", eod_l[0] - sod_l[0]); end
        end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL empty_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_gap_and_empty_word();
        clear_log();
        send_word(64'h0000_0000_0000_006E, 8'h01, 1'b0);
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0);
        drain(4);
        send_word(64'h6500_0000_0000_0000, 8'h80, 1'b1);
        drain(12);
        checks++; if (sod_l.size() != 1 || eod_l.size() != 1) begin
            errors++; $display("FAIL gap_strobes: sod=%0d eod=%0d want 1/1", sod_l.size(), eod_l.size());
        end
        checks++; if (en_l.size() != 2) begin errors++; $display("FAIL gap_en_count: got %0d want 2", en_l.size()); end
        if (en_l.size() == 2 && eod_l.size() == 1) begin
            checks++; if (cls_l[0] !== B3 || cls_l[1] !== B17) begin
                errors++; $display("FAIL gap_cls: got %h %h want %h %h", cls_l[0], cls_l[1], B3, B17);
            end
            checks++; if (en_l[1] - en_l[0] < 3) begin errors++; $display("FAIL gap_spacing: got %0d want >=3", en_l[1] - en_l[0]); end
            checks++; if (eod_l[0] != en_l[1] + 1) begin errors++; $display("FAIL gap_eod: got %0d want %0d", eod_l[0], en_l[1] + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_new_paren();
        test_back_to_back();
        test_sparse_keep();
        test_single_bytes();
        test_reset_mid_packet();
        test_empty_last();
        test_gap_and_empty_word();
        checks++; if (leak != 0)    begin errors++; $display("FAIL cls_without_en: got %0d cycles want 0", leak); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL sod_with_en: got %0d cycles want 0", overlap); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
